// File: rtl/noc_pkg.sv
// Shared NoC types: flit encoding, HEAD field layout, FSM state types and width defaults.
// The mesh nodes import the same package.
package noc_pkg;

   localparam int NOC_COORD_W = 4;
   localparam int NOC_DATA_W  = 32;

   typedef enum logic [1:0] {
      FLIT_BODY = 2'b00,
      FLIT_HEAD = 2'b01,
      FLIT_TAIL = 2'b10,
      FLIT_RSVD = 2'b11
   } flit_type_t;

   typedef struct packed {
      flit_type_t              ftype;
      logic [NOC_DATA_W-1:0]   data;
   } flit_t;

   // HEAD payload field index; bit offset is index*COORD_W, upper bits zero
   localparam int HEAD_SRC_Y_F = 0;
   localparam int HEAD_SRC_X_F = 1;
   localparam int HEAD_DST_Y_F = 2;
   localparam int HEAD_DST_X_F = 3;

   typedef enum logic [1:0] {TX_IDLE, TX_HEAD_WAIT, TX_BODY} tx_state_e;
   typedef enum logic       {RX_WAIT_HEAD, RX_PAYLOAD}        rx_state_e;

endpackage

// File: rtl/mesh_edge_ni_if.sv
// Host-side and mesh-side handshake bundle of the edge NI.
interface mesh_edge_ni_if #(
   parameter int COORD_W = noc_pkg::NOC_COORD_W,
   parameter int DATA_W  = noc_pkg::NOC_DATA_W
);
   logic               tx_valid;
   logic               tx_ready;
   logic [COORD_W-1:0] tx_dest_x;
   logic [COORD_W-1:0] tx_dest_y;
   logic [DATA_W-1:0]  tx_data;
   logic               tx_last;

   logic               out_valid;
   logic               out_ready;
   logic [DATA_W+1:0]  out_flit;

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W+1:0]  in_flit;

   logic               rx_valid;
   logic               rx_ready;
   logic [DATA_W-1:0]  rx_data;
   logic [COORD_W-1:0] rx_src_x;
   logic [COORD_W-1:0] rx_src_y;
   logic               rx_last;
   logic [7:0]         rx_err_cnt;

   modport slave (
      input  tx_valid, tx_dest_x, tx_dest_y, tx_data, tx_last, out_ready, in_valid, in_flit, rx_ready,
      output tx_ready, out_valid, out_flit, in_ready, rx_valid, rx_data, rx_src_x, rx_src_y, rx_last,
             rx_err_cnt
   );

   modport master (
      output tx_valid, tx_dest_x, tx_dest_y, tx_data, tx_last, out_ready, in_valid, in_flit, rx_ready,
      input  tx_ready, out_valid, out_flit, in_ready, rx_valid, rx_data, rx_src_x, rx_src_y, rx_last,
             rx_err_cnt
   );
endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; pointers wrap naturally, occupancy in a separate count.
module noc_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem[rd_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/mesh_edge_ni.sv
// Edge NI: packetizes host words into HEAD/BODY/TAIL flits toward the mesh and
// reassembles mesh flits into a source-tagged host word stream.
module mesh_edge_ni
   import noc_pkg::*;
#(
   parameter int SRC_X      = 0,
   parameter int SRC_Y      = 1,
   parameter int COORD_W    = NOC_COORD_W,
   parameter int DATA_W     = NOC_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   mesh_edge_ni_if.slave bus
);
   localparam int ENT_W = 1 + 2*COORD_W + DATA_W;

   // ---------------- TX ----------------
   logic [ENT_W-1:0]   fifo_rdata;
   logic               fifo_full, fifo_empty, fifo_pop;
   logic               hd_last;
   logic [COORD_W-1:0] hd_dx, hd_dy;
   logic [DATA_W-1:0]  hd_data, head_data;
   logic [DATA_W+1:0]  body_flit;

   tx_state_e          tx_state_q, tx_state_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W+1:0]  out_flit_q, out_flit_d;

   noc_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.tx_valid),
      .pop_i   (fifo_pop),
      .wdata_i ({bus.tx_last, bus.tx_dest_x, bus.tx_dest_y, bus.tx_data}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.tx_ready = !fifo_full;
   assign {hd_last, hd_dx, hd_dy, hd_data} = fifo_rdata;
   assign body_flit = {hd_last ? FLIT_TAIL : FLIT_BODY, hd_data};

   always_comb begin
      head_data = '0;
      head_data[HEAD_DST_X_F*COORD_W +: COORD_W] = hd_dx;
      head_data[HEAD_DST_Y_F*COORD_W +: COORD_W] = hd_dy;
      head_data[HEAD_SRC_X_F*COORD_W +: COORD_W] = COORD_W'(SRC_X);
      head_data[HEAD_SRC_Y_F*COORD_W +: COORD_W] = COORD_W'(SRC_Y);
   end

   // A FIFO entry is popped when it moves into the output register, so the
   // output register alone owns the flit while the mesh stalls.
   always_comb begin
      tx_state_d  = tx_state_q;
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      fifo_pop    = 1'b0;
      case (tx_state_q)
         TX_IDLE: if (!fifo_empty) begin
            out_valid_d = 1'b1;
            out_flit_d  = {FLIT_HEAD, head_data};
            tx_state_d  = TX_HEAD_WAIT;
         end
         TX_HEAD_WAIT: if (bus.out_ready) begin
            out_valid_d = 1'b1;
            out_flit_d  = body_flit;
            fifo_pop    = 1'b1;
            tx_state_d  = TX_BODY;
         end
         TX_BODY: if (!out_valid_q || bus.out_ready) begin
            if (out_valid_q && flit_type_t'(out_flit_q[DATA_W+1 -: 2]) == FLIT_TAIL) begin
               out_valid_d = 1'b0;
               tx_state_d  = TX_IDLE;
            end else if (!fifo_empty) begin
               out_valid_d = 1'b1;
               out_flit_d  = body_flit;
               fifo_pop    = 1'b1;
            end else begin
               out_valid_d = 1'b0;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_flit  = out_flit_q;

   // ---------------- RX ----------------
   rx_state_e          rx_state_q, rx_state_d;
   logic               rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]  rx_data_q, rx_data_d;
   logic [COORD_W-1:0] rx_src_x_q, rx_src_x_d, rx_src_y_q, rx_src_y_d;
   logic               rx_last_q, rx_last_d;
   logic [7:0]         rx_err_q, rx_err_d;
   logic               in_ready, in_hs, err_inc;
   flit_type_t         in_type;

   assign in_ready = (rx_state_q == RX_WAIT_HEAD) || !rx_valid_q || bus.rx_ready;
   assign in_hs    = bus.in_valid && in_ready;
   assign in_type  = flit_type_t'(bus.in_flit[DATA_W+1 -: 2]);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_valid_d = rx_valid_q && !bus.rx_ready;
      rx_data_d  = rx_data_q;
      rx_last_d  = rx_last_q;
      rx_src_x_d = rx_src_x_q;
      rx_src_y_d = rx_src_y_q;
      err_inc    = 1'b0;
      if (in_hs) begin
         case (rx_state_q)
            RX_WAIT_HEAD: if (in_type == FLIT_HEAD) begin
               rx_src_x_d = bus.in_flit[HEAD_SRC_X_F*COORD_W +: COORD_W];
               rx_src_y_d = bus.in_flit[HEAD_SRC_Y_F*COORD_W +: COORD_W];
               rx_state_d = RX_PAYLOAD;
            end else begin
               err_inc = 1'b1;
            end
            default: if (in_type == FLIT_BODY || in_type == FLIT_TAIL) begin
               rx_valid_d = 1'b1;
               rx_data_d  = bus.in_flit[DATA_W-1:0];
               rx_last_d  = (in_type == FLIT_TAIL);
               if (in_type == FLIT_TAIL) rx_state_d = RX_WAIT_HEAD;
            end else begin
               err_inc = 1'b1;
            end
         endcase
      end
      rx_err_d = (err_inc && rx_err_q != 8'hFF) ? rx_err_q + 8'd1 : rx_err_q;
   end

   assign bus.in_ready   = in_ready;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_src_x   = rx_src_x_q;
   assign bus.rx_src_y   = rx_src_y_q;
   assign bus.rx_last    = rx_last_q;
   assign bus.rx_err_cnt = rx_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q  <= TX_IDLE;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
         rx_state_q  <= RX_WAIT_HEAD;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         rx_last_q   <= 1'b0;
         rx_src_x_q  <= '0;
         rx_src_y_q  <= '0;
         rx_err_q    <= '0;
      end else begin
         tx_state_q  <= tx_state_d;
         out_valid_q <= out_valid_d;
         out_flit_q  <= out_flit_d;
         rx_state_q  <= rx_state_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         rx_last_q   <= rx_last_d;
         rx_src_x_q  <= rx_src_x_d;
         rx_src_y_q  <= rx_src_y_d;
         rx_err_q    <= rx_err_d;
      end
   end
endmodule

// File: tb/tb_mesh_edge_ni.sv
// Bench for mesh_edge_ni: directed scenarios plus randomized TX/RX traffic against a
// packet-level reference model checked every cycle.
module tb_mesh_edge_ni;
   import noc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mesh_edge_ni_if #(.COORD_W(4), .DATA_W(32)) bus ();

   mesh_edge_ni #(.SRC_X(0), .SRC_Y(1), .COORD_W(4), .DATA_W(32), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int ncmp = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      ncmp++;
      nerr++;
      $display("FAIL %s: event did not occur (expected it to) at %0t", name, $time);
   endtask

   function automatic logic [33:0] mk_flit(input flit_type_t t, input logic [31:0] d);
      flit_t f;
      f.ftype = t;
      f.data  = d;
      return f;
   endfunction

   function automatic logic [33:0] mk_head(input logic [3:0] dx, dy, sx, sy);
      return mk_flit(FLIT_HEAD, {16'h0, dx, dy, sx, sy});
   endfunction

   // ---------------- reference model + compare ----------------
   logic [33:0] txq[$];
   logic [33:0] tx_log[$];
   logic [32:0] rx_log[$];
   logic        m_tx_first = 1'b1;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_flit;
   logic        m_inpkt = 1'b0, m_held = 1'b0, m_last = 1'b0;
   logic [31:0] m_data = '0;
   logic [3:0]  m_src_x = '0, m_src_y = '0;
   logic [7:0]  m_err = '0;
   logic        exp_ir;
   logic [1:0]  t_in;

   always @(negedge clk) begin
      if (rst) begin
         txq.delete();
         m_tx_first = 1'b1;
         prev_stall = 1'b0;
         m_inpkt = 1'b0; m_held = 1'b0; m_last = 1'b0; m_data = '0;
         m_src_x = '0; m_src_y = '0; m_err = '0;
      end else begin
         if (prev_stall) begin
            check("out_hold_valid", bus.out_valid, 1'b1);
            check("out_hold_flit", bus.out_flit, prev_flit);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (txq.size() == 0) fail_now("out_flit_expected_none");
            else check("out_flit", bus.out_flit, txq.pop_front());
            tx_log.push_back(bus.out_flit);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_flit  = bus.out_flit;
         if (bus.tx_valid && bus.tx_ready) begin
            if (m_tx_first) txq.push_back(mk_head(bus.tx_dest_x, bus.tx_dest_y, 4'd0, 4'd1));
            txq.push_back(mk_flit(bus.tx_last ? FLIT_TAIL : FLIT_BODY, bus.tx_data));
            m_tx_first = bus.tx_last;
         end

         exp_ir = !m_inpkt || !m_held || bus.rx_ready;
         check("in_ready", bus.in_ready, exp_ir);
         check("rx_valid", bus.rx_valid, m_held);
         check("rx_err_cnt", bus.rx_err_cnt, m_err);
         check("rx_src", {bus.rx_src_x, bus.rx_src_y}, {m_src_x, m_src_y});
         if (m_held) begin
            check("rx_data", bus.rx_data, m_data);
            check("rx_last", bus.rx_last, m_last);
            if (bus.rx_ready) begin
               rx_log.push_back({m_last, m_data});
               m_held = 1'b0;
            end
         end
         if (bus.in_valid && exp_ir) begin
            t_in = bus.in_flit[33:32];
            if (!m_inpkt) begin
               if (t_in == 2'b01) begin
                  m_src_x = bus.in_flit[7:4];
                  m_src_y = bus.in_flit[3:0];
                  m_inpkt = 1'b1;
               end else if (m_err != 8'd255) m_err++;
            end else if (t_in == 2'b00 || t_in == 2'b10) begin
               m_held = 1'b1;
               m_data = bus.in_flit[31:0];
               m_last = (t_in == 2'b10);
               if (t_in == 2'b10) m_inpkt = 1'b0;
            end else if (m_err != 8'd255) m_err++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.tx_valid = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Leaves tx_valid high so consecutive calls push back-to-back
   task automatic push_word(input logic [3:0] dx, dy, input logic [31:0] d, input logic l);
      int n = 0;
      bus.tx_valid = 1'b1; bus.tx_dest_x = dx; bus.tx_dest_y = dy; bus.tx_data = d; bus.tx_last = l;
      @(negedge clk);
      while (!bus.tx_ready && n < 500) begin
         tick();
         @(negedge clk);
         n++;
      end
      if (!bus.tx_ready) fail_now("tx_push_timeout");
      tick();
   endtask

   task automatic send_flit(input logic [33:0] f);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_flit  = f;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
         tick();
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) fail_now("in_send_timeout");
      tick();
   endtask

   logic tx_done, rx_done;
   int   acc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with traffic offered on both sides
      bus.tx_valid = 1'b1; bus.tx_dest_x = 4'd2; bus.tx_dest_y = 4'd2; bus.tx_data = 32'h1234; bus.tx_last = 1'b1;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_flit = mk_head(4'd0, 4'd1, 4'd5, 4'd5);
      bus.rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_ready", bus.tx_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_flit", bus.out_flit, 34'h0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_rx_state", {bus.rx_valid, bus.rx_last, bus.rx_data, bus.rx_src_x, bus.rx_src_y, bus.rx_err_cnt}, 64'h0);
      tick();
      bus.tx_valid = 1'b0; bus.in_valid = 1'b0; rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 1'b0);
      check("post_rst_rx_src", {bus.rx_src_x, bus.rx_src_y}, 8'h00);
      tick();

      // single-word packet, latency N+2 for HEAD
      tx_log.delete();
      bus.tx_valid = 1'b1; bus.tx_dest_x = 4'd2; bus.tx_dest_y = 4'd1; bus.tx_data = 32'hCAFE0001; bus.tx_last = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      @(negedge clk); check("single_n1_valid", bus.out_valid, 1'b0);
      tick();
      @(negedge clk); check("single_head", {bus.out_valid, bus.out_flit}, {1'b1, 34'h1_0000_2101});
      tick();
      @(negedge clk); check("single_tail", {bus.out_valid, bus.out_flit}, {1'b1, 34'h2_CAFE_0001});
      tick();
      @(negedge clk); check("single_done", bus.out_valid, 1'b0);
      tick();

      // 4-word packet under out_ready 1,0,0,1,...
      tx_log.delete();
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
               tick();
            end
         end
         begin
            for (int i = 0; i < 4; i++) push_word(4'd1, 4'd2, 32'hA0 + i, i == 3);
            bus.tx_valid = 1'b0;
         end
      join
      bus.out_ready = 1'b1;
      check("pkt4_len", tx_log.size(), 5);
      if (tx_log.size() == 5) begin
         check("pkt4_f0", tx_log[0], 34'h1_0000_1201);
         check("pkt4_f1", tx_log[1], 34'h0_0000_00A0);
         check("pkt4_f2", tx_log[2], 34'h0_0000_00A1);
         check("pkt4_f3", tx_log[3], 34'h0_0000_00A2);
         check("pkt4_f4", tx_log[4], 34'h2_0000_00A3);
      end

      // FIFO fill with out_ready low
      tx_log.delete();
      bus.out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         bus.tx_valid = 1'b1; bus.tx_dest_x = 4'd3; bus.tx_dest_y = 4'd3;
         bus.tx_data = 32'hD0 + i; bus.tx_last = (i == 3);
         @(negedge clk);
         if (bus.tx_ready) acc++;
         tick();
      end
      bus.tx_valid = 1'b0;
      @(negedge clk);
      check("fill_accepted", acc, 4);
      check("fill_tx_ready", bus.tx_ready, 1'b0);
      tick();
      bus.out_ready = 1'b1;
      repeat (10) tick();
      check("fill_drain_len", tx_log.size(), 5);
      if (tx_log.size() == 5) begin
         check("fill_f0", tx_log[0], 34'h1_0000_3301);
         check("fill_f1", tx_log[1], 34'h0_0000_00D0);
         check("fill_f4", tx_log[4], 34'h2_0000_00D3);
      end

      // RX packet with host stall
      rx_log.delete();
      send_flit(mk_head(4'd0, 4'd1, 4'd3, 4'd2));
      send_flit(mk_flit(FLIT_BODY, 32'h11));
      bus.rx_ready = 1'b0;
      bus.in_flit = mk_flit(FLIT_BODY, 32'h22);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rx_stall_in_ready", bus.in_ready, 1'b0);
         check("rx_stall_word", {bus.rx_valid, bus.rx_last, bus.rx_data}, {2'b10, 32'h11});
         tick();
      end
      bus.rx_ready = 1'b1;
      send_flit(mk_flit(FLIT_BODY, 32'h22));
      send_flit(mk_flit(FLIT_TAIL, 32'h33));
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check("rx_src_32", {bus.rx_src_x, bus.rx_src_y}, 8'h32);
      check("rx_log_len", rx_log.size(), 3);
      if (rx_log.size() == 3) begin
         check("rx_w0", rx_log[0], {1'b0, 32'h11});
         check("rx_w1", rx_log[1], {1'b0, 32'h22});
         check("rx_w2", rx_log[2], {1'b1, 32'h33});
      end

      // protocol errors, then saturation
      do_reset();
      send_flit(mk_flit(FLIT_BODY, 32'h5));
      send_flit(mk_head(4'd0, 4'd1, 4'd1, 4'd1));
      send_flit(mk_head(4'd0, 4'd1, 4'd2, 4'd2));
      bus.in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("err_cnt_2", bus.rx_err_cnt, 8'd2);
      check("err_no_rx_valid", bus.rx_valid, 1'b0);
      tick();
      bus.in_valid = 1'b1; bus.in_flit = mk_flit(FLIT_RSVD, 32'h0);
      repeat (260) tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("err_cnt_sat", bus.rx_err_cnt, 8'd255);
      tick();

      // reset in the middle of a TX packet
      do_reset();
      for (int i = 0; i < 3; i++) push_word(4'd4, 4'd4, 32'hE0 + i, 1'b0);
      bus.tx_valid = 1'b0;
      repeat (2) tick();
      do_reset();
      tx_log.delete();
      push_word(4'd1, 4'd1, 32'h77, 1'b1);
      bus.tx_valid = 1'b0;
      repeat (6) tick();
      check("rst_mid_len", tx_log.size(), 2);
      if (tx_log.size() == 2) begin
         check("rst_mid_head", tx_log[0], 34'h1_0000_1101);
         check("rst_mid_tail", tx_log[1], 34'h2_0000_0077);
      end

      // randomized traffic on both sides
      do_reset();
      tx_done = 1'b0;
      rx_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 40; p++) begin
               int len;
               logic [3:0] dx, dy;
               len = $urandom_range(1, 5);
               dx = 4'($urandom); dy = 4'($urandom);
               for (int w = 0; w < len; w++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     bus.tx_valid = 1'b0;
                     repeat ($urandom_range(1, 3)) tick();
                  end
                  push_word(dx, dy, $urandom, w == len - 1);
               end
            end
            bus.tx_valid = 1'b0;
            tx_done = 1'b1;
         end
         begin
            while (!tx_done) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
            bus.out_ready = 1'b1;
         end
         begin
            for (int p = 0; p < 40; p++) begin
               int nb;
               if ($urandom_range(0, 9) == 0)
                  send_flit(mk_flit(($urandom_range(0, 1) == 0) ? FLIT_TAIL : FLIT_RSVD, $urandom));
               send_flit(mk_flit(FLIT_HEAD, {16'h0, 16'($urandom)}));
               nb = $urandom_range(0, 3);
               for (int b = 0; b < nb; b++) begin
                  if ($urandom_range(0, 9) == 0)
                     send_flit(mk_flit(($urandom_range(0, 1) == 0) ? FLIT_HEAD : FLIT_RSVD, $urandom));
                  send_flit(mk_flit(FLIT_BODY, $urandom));
               end
               send_flit(mk_flit(FLIT_TAIL, $urandom));
               bus.in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
            end
            bus.in_valid = 1'b0;
            rx_done = 1'b1;
         end
         begin
            while (!rx_done) begin
               bus.rx_ready = ($urandom_range(0, 2) != 0);
               tick();
            end
            bus.rx_ready = 1'b1;
         end
      join
      repeat (20) tick();
      check("tx_drained", txq.size(), 0);
      check("rx_drained", bus.rx_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
